// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a counted run of 8-bit multiplier products into an ACC_W-bit accumulator
// Optional macro ACC_SATURATE_EN: clamp acc at all-ones on overflow instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so that count=0 can be loaded as a full 2^CNT_W run.
    localparam logic [CNT_W:0] FULL_RUN = {1'b1, {CNT_W{1'b0}}};
    localparam int             PROD_PAD = ACC_W + 1 - 8;

    state_t           state_q;
    logic [CNT_W:0]   remaining_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic [ACC_W:0]   sum;
    logic             xfer;
    logic             last_xfer;

    // ready_q is high exactly while in ACC, so it qualifies the handshake alone.
    assign xfer      = prod_valid && ready_q;
    assign last_xfer = xfer && (remaining_q == {{CNT_W{1'b0}}, 1'b1});

    always_comb begin
        sum        = {1'b0, acc_q} + {{PROD_PAD{1'b0}}, prod};
        overflow_d = overflow_q | sum[ACC_W];
`ifdef ACC_SATURATE_EN
        acc_d      = overflow_d ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_d      = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            overflow_q  <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= ACC;
                        remaining_q <= (count == '0) ? FULL_RUN : {1'b0, count};
                        acc_q       <= '0;
                        overflow_q  <= 1'b0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ACC: begin
                    if (xfer) begin
                        acc_q       <= acc_d;
                        overflow_q  <= overflow_d;
                        remaining_q <= remaining_q - 1'b1;
                        if (last_xfer) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign prod_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign acc        = acc_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 10, accumulator width in bits (legal range 9..16).
REQ-002 SHALL have parameter CNT_W, default 4, width of the product-count field.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to begin one accumulation run.
REQ-006 SHALL have port count, input, CNT_W, number of products to sum; 0 means 2^CNT_W.
REQ-007 SHALL have port prod, input, 8, unsigned product from the 4x4 array multiplier.
REQ-008 SHALL have port prod_valid, input, 1, prod is valid this cycle.
REQ-009 SHALL have port prod_ready, output, 1, block accepts prod this cycle.
REQ-010 SHALL have port busy, output, 1, run in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking a completed run.
REQ-012 SHALL have port acc, output, ACC_W, accumulated sum.
REQ-013 SHALL have port overflow, output, 1, sticky flag set when the sum exceeded 2^ACC_W-1 during the run.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, DONE.
REQ-015 IDLE: prod_ready=0, busy=0, done=0; start=1 -> latch count into remaining counter, clear acc and overflow, go to ACC next cycle.
REQ-016 ACC: prod_ready=1, busy=1; transfer occurs only when prod_valid=1 and prod_ready=1 in the same cycle.
REQ-017 On each transfer SHALL add zero-extended prod to acc and decrement remaining by one.
REQ-018 Cycles in ACC with prod_valid=0 SHALL hold acc, overflow and remaining unchanged.
REQ-019 The transfer with remaining=1 (or the 2^CNT_W-th transfer when count=0) SHALL be the last; FSM goes to DONE on the following cycle.
REQ-020 DONE: done=1, busy=1, prod_ready=0 for exactly one cycle, then unconditional return to IDLE.
REQ-021 acc and overflow SHALL be valid in the DONE cycle and held in IDLE until the next accepted start.
REQ-022 start SHALL be ignored in ACC and DONE; count is sampled only on the IDLE start edge.
REQ-023 Carry-out of the ACC_W-bit add SHALL set overflow; overflow SHALL never clear mid-run.
REQ-024 Latency: done asserts exactly one cycle after the last transfer; run length is unaffected by prod_valid gaps except by their duration.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, acc=0, overflow=0, remaining=0, done=0, busy=0, prod_ready=0, regardless of clk.
REQ-026 rst asserted mid-run SHALL abandon the run with no done pulse; first start after rst release begins a fresh run.

Configuration
REQ-027 Macro ACC_SATURATE_EN defined: on overflow acc SHALL clamp to 2^ACC_W-1 and remain clamped for the rest of the run.
REQ-028 Macro ACC_SATURATE_EN undefined: acc SHALL wrap modulo 2^ACC_W; overflow behaviour per REQ-023 in both builds.

Verification
REQ-029 count=3, prods 0x09,0xE1,0x01 with prod_valid every cycle -> acc=0x0EB, overflow=0, done one cycle after third transfer.
REQ-030 count=5, five prods 0xE1 -> overflow=1; acc=0x065 without ACC_SATURATE_EN, acc=0x3FF with it.
REQ-031 count=0, sixteen prods 0x01 with prod_valid toggling 1/0 -> acc=0x010, exactly 16 transfers, single done pulse.
REQ-032 start pulsed during ACC and DONE with a different count -> run length and acc unaffected, no extra run.
REQ-033 rst asserted after two of four transfers (count=4) -> all outputs 0 asynchronously, no done; new run count=1, prod 0x04 -> acc=0x004.
